// File: rtl/gpi_pkg.sv
// Shared constants and helpers for the GPI input conditioning slice.
package gpi_pkg;

  localparam int unsigned GPI_WIDTH            = 8;
  localparam int unsigned GPI_DEBOUNCE_DEFAULT = 4;

  // Debounce counter width; never narrower than one bit.
  function automatic int unsigned gpi_cnt_w(input int unsigned cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// One input bit: 2-FF synchroniser, debounce counter, stable level, edge pulses, sticky pending flag.
module gpi_debounce_bit
  import gpi_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = GPI_DEBOUNCE_DEFAULT
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic gpi_raw,
  input  logic en,
  input  logic rise_en,
  input  logic fall_en,
  input  logic pend_clr,
  output logic gpi_clean,
  output logic rise,
  output logic fall,
  output logic pend
);

  localparam int unsigned     CNT_W = gpi_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      gpi_clean <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      pend      <= 1'b0;
    end else begin
      sync1 <= gpi_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (!en || (sync2 == gpi_clean)) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Accept: the new level and its edge pulse appear on the same edge.
        gpi_clean <= sync2;
        cnt       <= '0;
        rise      <= sync2;
        fall      <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // Set terms come last so a coincident clear loses.
      pend <= (pend & ~pend_clr) | (rise & rise_en) | (fall & fall_en);
    end
  end

endmodule

// File: rtl/gpi_input_conditioner.sv
// Conditions raw GPI pads: per-bit synchronise/debounce/edge-detect, plus combined interrupt.
module gpi_input_conditioner
  import gpi_pkg::*;
#(
  parameter int unsigned WIDTH           = GPI_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = GPI_DEBOUNCE_DEFAULT
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [WIDTH-1:0] gpi_raw,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] pend_clr,
  output logic [WIDTH-1:0] gpi_clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] pend,
  output logic             irq
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpi_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .gpi_raw   (gpi_raw[i]),
      .en        (en[i]),
      .rise_en   (rise_en[i]),
      .fall_en   (fall_en[i]),
      .pend_clr  (pend_clr[i]),
      .gpi_clean (gpi_clean[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .pend      (pend[i])
    );
  end

  assign irq = |pend;

endmodule

// File: tb/tb_gpi_input_conditioner.sv
// Directed bench for gpi_input_conditioner (DEBOUNCE_CYCLES=4 main instance, =1 boundary instance).
module tb_gpi_input_conditioner;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [7:0] gpi_raw, gpi_raw1, en, rise_en, fall_en, pend_clr;
  logic [7:0] gpi_clean, rise, fall, pend;
  logic [7:0] gpi_clean1, rise1, fall1, pend1;
  logic       irq, irq1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  seen;

  always #5 PCLK = ~PCLK;

  gpi_input_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) u_dut (
    .PCLK(PCLK), .PRESET(PRESET), .gpi_raw(gpi_raw), .en(en),
    .rise_en(rise_en), .fall_en(fall_en), .pend_clr(pend_clr),
    .gpi_clean(gpi_clean), .rise(rise), .fall(fall), .pend(pend), .irq(irq)
  );

  gpi_input_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .gpi_raw(gpi_raw1), .en(en),
    .rise_en(rise_en), .fall_en(fall_en), .pend_clr(pend_clr),
    .gpi_clean(gpi_clean1), .rise(rise1), .fall(fall1), .pend(pend1), .irq(irq1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic do_reset(input logic [7:0] raw, input logic [7:0] e,
                          input logic [7:0] re, input logic [7:0] fe);
    PRESET   = 1'b1;
    gpi_raw  = raw;
    gpi_raw1 = 8'h00;
    en       = e;
    rise_en  = re;
    fall_en  = fe;
    pend_clr = 8'h00;
    tick(2);
    PRESET = 1'b0;
  endtask

  initial begin
    // Reset then steady state
    PRESET = 1'b1; gpi_raw = 8'hFF; gpi_raw1 = 8'h00; en = 8'hFF;
    rise_en = 8'h00; fall_en = 8'h00; pend_clr = 8'h00;
    tick(2);
    check_eq("rst_clean", gpi_clean, 8'h00);
    check_eq("rst_rise",  rise,      8'h00);
    check_eq("rst_pend",  pend,      8'h00);
    check_eq("rst_irq",   irq,       1'b0);
    PRESET = 1'b0;
    tick(5);
    check_eq("steady_clean_e5", gpi_clean, 8'h00);
    tick(1);
    check_eq("steady_clean_e6", gpi_clean, 8'hFF);
    check_eq("steady_rise_e6",  rise,      8'hFF);
    tick(1);
    check_eq("steady_rise_e7",  rise,      8'h00);

    // Latency and edge on bit 0
    do_reset(8'h00, 8'h01, 8'h01, 8'h00);
    tick(3);
    gpi_raw = 8'h01;
    tick(5);
    check_eq("lat_clean_e5", gpi_clean, 8'h00);
    tick(1);
    check_eq("lat_clean_e6", gpi_clean, 8'h01);
    check_eq("lat_rise_e6",  rise,      8'h01);
    check_eq("lat_pend_e6",  pend,      8'h00);
    tick(1);
    check_eq("lat_rise_e7",  rise,      8'h00);
    check_eq("lat_pend_e7",  pend,      8'h01);
    check_eq("lat_irq_e7",   irq,       1'b1);

    // Glitch rejection: 3-cycle pulse rejected
    do_reset(8'h00, 8'h01, 8'h01, 8'h01);
    tick(3);
    gpi_raw = 8'h01;
    tick(3);
    gpi_raw = 8'h00;
    seen = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen |= rise | gpi_clean;
    end
    check_eq("glitch3_seen", seen, 8'h00);
    check_eq("glitch3_pend", pend, 8'h00);

    // 4-cycle pulse accepted: rise at edge 6, fall at edge 10
    gpi_raw = 8'h01;
    tick(4);
    gpi_raw = 8'h00;
    tick(2);
    check_eq("pulse4_rise_e6",  rise,      8'h01);
    check_eq("pulse4_clean_e6", gpi_clean, 8'h01);
    tick(1);
    check_eq("pulse4_rise_e7",  rise,      8'h00);
    tick(2);
    check_eq("pulse4_fall_e9",  fall,      8'h00);
    tick(1);
    check_eq("pulse4_fall_e10",  fall,      8'h01);
    check_eq("pulse4_clean_e10", gpi_clean, 8'h00);
    tick(1);
    check_eq("pulse4_fall_e11", fall, 8'h00);
    check_eq("pulse4_pend",     pend, 8'h01);

    // Clear vs set on bit 1
    do_reset(8'h00, 8'h02, 8'h02, 8'h02);
    tick(3);
    gpi_raw = 8'h02;
    tick(7);
    check_eq("clr_pend_set", pend, 8'h02);
    gpi_raw = 8'h00;
    tick(6);
    check_eq("clr_fall", fall, 8'h02);
    pend_clr = 8'h02;
    tick(1);
    pend_clr = 8'h00;
    check_eq("clr_set_wins", pend, 8'h02);
    tick(2);
    pend_clr = 8'h02;
    tick(1);
    pend_clr = 8'h00;
    check_eq("clr_lone_pend", pend, 8'h00);
    check_eq("clr_lone_irq",  irq,  1'b0);
    pend_clr = 8'h02;
    tick(1);
    pend_clr = 8'h00;
    check_eq("clr_on_zero", pend, 8'h00);

    // Enable gating on bit 2, dropped with counter at 2
    do_reset(8'h00, 8'h04, 8'h04, 8'h04);
    tick(3);
    gpi_raw = 8'h04;
    tick(4);
    en = 8'h00;
    seen = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      seen |= rise | fall | gpi_clean;
    end
    check_eq("en_gated_seen", seen, 8'h00);
    en = 8'h04;
    tick(3);
    check_eq("en_reen_e3_clean", gpi_clean, 8'h00);
    tick(1);
    check_eq("en_reen_e4_clean", gpi_clean, 8'h04);
    check_eq("en_reen_e4_rise",  rise,      8'h04);

    // Masking on bit 3: only the fall sets pending
    do_reset(8'h00, 8'h08, 8'h00, 8'hFF);
    tick(3);
    gpi_raw = 8'h08;
    tick(6);
    check_eq("mask_rise", rise, 8'h08);
    tick(1);
    check_eq("mask_pend_after_rise", pend, 8'h00);
    tick(3);
    gpi_raw = 8'h00;
    tick(6);
    check_eq("mask_fall", fall, 8'h08);
    check_eq("mask_pend_at_fall", pend, 8'h00);
    tick(1);
    check_eq("mask_pend_after_fall", pend, 8'h08);
    check_eq("mask_irq", irq, 1'b1);

    // Reset mid-debounce produces no pulse
    do_reset(8'h00, 8'h01, 8'h01, 8'h01);
    gpi_raw = 8'h01;
    tick(4);
    PRESET = 1'b1;
    tick(1);
    check_eq("rst_mid_rise",  rise,      8'h00);
    check_eq("rst_mid_clean", gpi_clean, 8'h00);
    PRESET = 1'b0;
    gpi_raw = 8'h00;

    // DEBOUNCE_CYCLES=1 latency of 3 edges
    do_reset(8'h00, 8'h01, 8'h01, 8'h00);
    tick(2);
    gpi_raw1 = 8'h01;
    tick(2);
    check_eq("db1_clean_e2", gpi_clean1, 8'h00);
    tick(1);
    check_eq("db1_clean_e3", gpi_clean1, 8'h01);
    check_eq("db1_rise_e3",  rise1,      8'h01);
    tick(1);
    check_eq("db1_irq_e4",   irq1,       1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpi_input_conditioner.md
Name: gpi_input_conditioner

Overview:
- Sits directly upstream of the GPI peripheral, between the raw external input pins and its `gpi` input.
- Per bit, it synchronises the asynchronous pad signal (2-FF) and debounces it with a cycle counter.
- It detects rising/falling edges on the debounced value and keeps sticky per-bit edge-pending flags plus a combined interrupt line.
- The debounced vector drives GPI `gpi`; the edge pulses and pending flags feed a future interrupt/status register.

Parameters:
- WIDTH, 8, number of input bits; matches the GPI `gpi` width.
- DEBOUNCE_CYCLES, 4, consecutive PCLK cycles a synchronised level must differ from the stable value before it is accepted; legal range 1..65535.

Ports:
- PCLK  input  1  system clock.
- PRESET  input  1  synchronous, active-high reset.
- gpi_raw  input  WIDTH  asynchronous pad inputs.
- en  input  WIDTH  per-bit enable; driven from GPI cr.
- rise_en  input  WIDTH  per-bit enable for setting pending on a rising edge.
- fall_en  input  WIDTH  per-bit enable for setting pending on a falling edge.
- pend_clr  input  WIDTH  one-cycle pulse; clears the matching pending bits.
- gpi_clean  output  WIDTH  debounced stable level; connects to GPI gpi.
- rise  output  WIDTH  one-cycle pulse when gpi_clean[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when gpi_clean[i] goes 1->0.
- pend  output  WIDTH  sticky edge-pending flags.
- irq  output  1  OR-reduction of pend.

Behaviour:
- One clock, PCLK. Reset is synchronous and active-high on PRESET. Every flop, including the synchroniser, clears only on a PCLK edge with PRESET=1.
- Reset values: sync1, sync2, gpi_clean, rise, fall, pend, every counter = 0; irq = 0.
- Synchroniser: sync1 <= gpi_raw; sync2 <= sync1. Always runs, independent of en.
- Per-bit debounce counter:
  - Width CNT_W = max(1, clog2(DEBOUNCE_CYCLES)).
  - If en[i]=0: counter held at 0, gpi_clean[i] frozen, rise[i]/fall[i] = 0.
  - If sync2[i]==gpi_clean[i]: counter <= 0. Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
  - If sync2[i]!=gpi_clean[i] and counter != DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If sync2[i]!=gpi_clean[i] and counter == DEBOUNCE_CYCLES-1: gpi_clean[i] <= sync2[i], counter <= 0, and rise[i] or fall[i] <= 1 on the same edge.
- Latency: a clean level change on gpi_raw appears on gpi_clean exactly 2+DEBOUNCE_CYCLES PCLK edges later.
- Acceptance threshold: a raw pulse lasting >= DEBOUNCE_CYCLES cycles is accepted; a shorter one is rejected.
- rise/fall are registered. They are high for exactly one cycle, coincident with the first cycle of the new gpi_clean value. They are never both high for the same bit.
- Pending:
  - pend[i] <= (pend[i] & ~pend_clr[i]) | (rise[i]&rise_en[i]) | (fall[i]&fall_en[i]).
  - The set is evaluated on the cycle the rise/fall pulse is visible.
  - Simultaneous set and clear on the same bit: set wins.
  - pend_clr on a bit that is already 0 has no effect.
- irq = |pend. Combinational from the pend flops; no extra latency.
- en deassert mid-count: counter cleared next edge. On re-enable, the full debounce window restarts from 0. gpi_clean keeps its frozen value and does not jump.
- PRESET mid-debounce: all state returns to reset values; no edge pulse is generated by reset itself.
- DEBOUNCE_CYCLES=1: the accept branch fires on the first cycle of mismatch (counter is always 0); latency 3 edges.

Decomposition:
- Shared package gpi_pkg holds:
  - GPI_WIDTH = 8.
  - GPI_DEBOUNCE_DEFAULT = 4.
  - a constant function gpi_cnt_w(cycles) returning CNT_W.
- The per-bit logic (sync pair, counter, stable flop, edge pulses, pending flop) lives in the natural sub-module gpi_debounce_bit, instantiated WIDTH times in a generate loop.
- The top level adds only the irq reduction.

Test Plan:
- Reset then steady state: PRESET=1 for 2 cycles with gpi_raw=8'hFF, en=8'hFF, then release -> gpi_clean=8'h00 during reset; gpi_clean=8'hFF exactly 6 edges after release; rise=8'hFF for exactly one cycle.
- Latency and edge (DEBOUNCE_CYCLES=4, en=8'h01, rise_en=8'h01): gpi_raw[0] 0->1 held -> gpi_clean[0]=1 on the 6th edge; rise[0] pulses 1 cycle; pend[0]=1; irq=1 the same cycle.
- Glitch rejection: gpi_raw[0] high for 3 cycles, then low -> gpi_clean, rise and pend stay 0. Repeat with a 4-cycle pulse -> accepted; rise then fall, each a single pulse, 4 cycles apart.
- Clear vs set: pend[1]=1, then assert pend_clr[1] on the same cycle a new fall[1] (fall_en[1]=1) pulses -> pend[1] remains 1. A later lone pend_clr[1] -> pend[1]=0 and irq=0.
- Enable gating: en[2] dropped at counter=2 mid-transition -> gpi_clean[2] unchanged, no pulse. Re-enable with the input still changed -> accepted exactly 4 edges after re-enable.
- Masking: rise_en=8'h00, fall_en=8'hFF, bit 3 toggles 0->1->0 with stable windows -> rise[3] and fall[3] each pulse once; pend[3] set only after the fall.
